// File: rtl/video_pkg.sv
// Shared raster timing defaults for the video timing generator and the scandoubler bench.
package video_pkg;

    localparam int unsigned VID_HCW = 10;
    localparam int unsigned VID_VCW = 9;

    localparam int unsigned VID_HA  = 720;
    localparam int unsigned VID_HFP = 24;
    localparam int unsigned VID_HS  = 64;
    localparam int unsigned VID_HBP = 88;

    localparam int unsigned VID_VA  = 288;
    localparam int unsigned VID_VFP = 2;
    localparam int unsigned VID_VS  = 3;
    localparam int unsigned VID_VBP = 19;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned VID_HT = axis_total(VID_HA, VID_HFP, VID_HS, VID_HBP);
    localparam int unsigned VID_VT = axis_total(VID_VA, VID_VFP, VID_VS, VID_VBP);

endpackage

// File: rtl/timing_axis.sv
// One raster axis: position counter with wrap, plus registered blank and sync decode.
module timing_axis
    import video_pkg::*;
#(
    parameter int unsigned W      = VID_HCW,
    parameter int unsigned ACTIVE = VID_HA,
    parameter int unsigned FP     = VID_HFP,
    parameter int unsigned SYNC   = VID_HS,
    parameter int unsigned BP     = VID_HBP
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_advance,
    input  logic         i_extend,
    output logic [W-1:0] o_count,
    output logic         o_blank,
    output logic         o_sync,
    output logic         o_last_c
);

    localparam int unsigned TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] LAST_EXT = W'(TOTAL);
    localparam logic [W-1:0] BLK_BEG  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] r_count;
    logic         r_blank;
    logic         r_sync;
    logic [W-1:0] w_next;
    logic         w_last;

    // Extended period adds one position past the nominal last one.
    always_comb begin
        w_last = i_extend ? (r_count == LAST_EXT) : (r_count == LAST);
        w_next = w_last ? '0 : r_count + W'(1);
    end

    // Blank/sync decode from the next position so they land with the count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
            r_blank <= 1'b0;
            r_sync  <= 1'b0;
        end else if (i_advance) begin
            r_count <= w_next;
            r_blank <= (w_next >= BLK_BEG);
            r_sync  <= (w_next >= SYNC_BEG) && (w_next < SYNC_END);
        end
    end

    assign o_count  = r_count;
    assign o_blank  = r_blank;
    assign o_sync   = r_sync;
    assign o_last_c = w_last;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters, blank/sync, start pulses and interlaced field.
module video_timing
    import video_pkg::*;
#(
    parameter int unsigned HCW = VID_HCW,
    parameter int unsigned VCW = VID_VCW,
    parameter int unsigned HA  = VID_HA,
    parameter int unsigned HFP = VID_HFP,
    parameter int unsigned HS  = VID_HS,
    parameter int unsigned HBP = VID_HBP,
    parameter int unsigned VA  = VID_VA,
    parameter int unsigned VFP = VID_VFP,
    parameter int unsigned VS  = VID_VS,
    parameter int unsigned VBP = VID_VBP
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ce,
    input  logic           interlace,
    output logic [1:0]     blank,
    output logic [1:0]     sync,
    output logic [HCW-1:0] hcount,
    output logic [VCW-1:0] vcount,
    output logic           field,
    output logic           hstart,
    output logic           vstart
);

    localparam int unsigned HT = axis_total(HA, HFP, HS, HBP);
    localparam int unsigned VT = axis_total(VA, VFP, VS, VBP);

    if (HT > (32'd1 << HCW)) begin : g_bad_hcw
        $error("video_timing: HT does not fit in HCW bits");
    end
    if ((VT + 1) > (32'd1 << VCW)) begin : g_bad_vcw
        $error("video_timing: VT+1 does not fit in VCW bits");
    end

    logic w_h_last;
    logic w_v_last;
    logic w_line_adv;
    logic w_frame_wrap;
    logic w_h_blank;
    logic w_h_sync;
    logic w_v_blank;
    logic w_v_sync;
    logic r_ilace;
    logic r_field;
    logic r_hstart;
    logic r_vstart;

    assign w_line_adv   = ce & w_h_last;
    assign w_frame_wrap = w_line_adv & w_v_last;

    timing_axis #(
        .W(HCW), .ACTIVE(HA), .FP(HFP), .SYNC(HS), .BP(HBP)
    ) u_haxis (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_advance(ce),
        .i_extend (1'b0),
        .o_count  (hcount),
        .o_blank  (w_h_blank),
        .o_sync   (w_h_sync),
        .o_last_c (w_h_last)
    );

    // Field 1 of an interlaced frame carries one extra blank line.
    timing_axis #(
        .W(VCW), .ACTIVE(VA), .FP(VFP), .SYNC(VS), .BP(VBP)
    ) u_vaxis (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_advance(w_line_adv),
        .i_extend (r_ilace & r_field),
        .o_count  (vcount),
        .o_blank  (w_v_blank),
        .o_sync   (w_v_sync),
        .o_last_c (w_v_last)
    );

    // Interlace request only takes effect at the frame boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ilace  <= 1'b0;
            r_field  <= 1'b0;
            r_hstart <= 1'b1;
            r_vstart <= 1'b1;
        end else if (ce) begin
            r_hstart <= w_h_last;
            r_vstart <= w_h_last & w_v_last;
            if (w_frame_wrap) begin
                r_ilace <= interlace;
                r_field <= interlace & ~r_field;
            end
        end
    end

    assign blank  = {w_v_blank, w_h_blank};
    assign sync   = {w_v_sync, w_h_sync};
    assign field  = r_field;
    assign hstart = r_hstart;
    assign vstart = r_vstart;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench: default-timing instance for line behaviour, small-timing instance for frames.
module tb_video_timing;

    typedef struct packed {
        logic [1:0] blank;
        logic [1:0] sync;
        logic [9:0] h;
        logic [8:0] v;
        logic       field;
        logic       hstart;
        logic       vstart;
    } obs_t;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
    } tim_t;

    typedef struct packed {
        int   h;
        int   v;
        logic field;
    } mstate_t;

    localparam tim_t TD = '{ha:720, hfp:24, hs:64, hbp:88, va:288, vfp:2, vs:3, vbp:19};
    localparam tim_t TS = '{ha:8, hfp:2, hs:3, hbp:3, va:6, vfp:1, vs:2, vbp:2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic d_rst = 1'b0, d_ce = 1'b0, d_il = 1'b0;
    logic s_rst = 1'b0, s_ce = 1'b0, s_il = 1'b0;
    logic [1:0] d_blank, d_sync, s_blank, s_sync;
    logic [9:0] d_hcount, s_hcount;
    logic [8:0] d_vcount, s_vcount;
    logic d_field, d_hstart, d_vstart, s_field, s_hstart, s_vstart;

    video_timing u_dut_d (
        .clock(clk), .reset(d_rst), .ce(d_ce), .interlace(d_il),
        .blank(d_blank), .sync(d_sync), .hcount(d_hcount), .vcount(d_vcount),
        .field(d_field), .hstart(d_hstart), .vstart(d_vstart)
    );

    video_timing #(
        .HA(8), .HFP(2), .HS(3), .HBP(3), .VA(6), .VFP(1), .VS(2), .VBP(2)
    ) u_dut_s (
        .clock(clk), .reset(s_rst), .ce(s_ce), .interlace(s_il),
        .blank(s_blank), .sync(s_sync), .hcount(s_hcount), .vcount(s_vcount),
        .field(s_field), .hstart(s_hstart), .vstart(s_vstart)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    obs_t q_d[$];
    obs_t q_s[$];
    mstate_t md = '0;
    mstate_t ms = '0;

    function automatic mstate_t m_step(input mstate_t s, input tim_t t, input logic il);
        int ht = t.ha + t.hfp + t.hs + t.hbp;
        int lines = t.va + t.vfp + t.vs + t.vbp + (s.field ? 1 : 0);
        mstate_t n = s;
        if (s.h == ht - 1) begin
            n.h = 0;
            if (s.v == lines - 1) begin
                n.v = 0;
                n.field = il ? ~s.field : 1'b0;
            end else begin
                n.v = s.v + 1;
            end
        end else begin
            n.h = s.h + 1;
        end
        return n;
    endfunction

    function automatic obs_t m_decode(input mstate_t s, input tim_t t);
        obs_t o;
        o.blank[0] = (s.h >= t.ha);
        o.blank[1] = (s.v >= t.va);
        o.sync[0]  = (s.h >= t.ha + t.hfp) && (s.h < t.ha + t.hfp + t.hs);
        o.sync[1]  = (s.v >= t.va + t.vfp) && (s.v < t.va + t.vfp + t.vs);
        o.h        = 10'(s.h);
        o.v        = 9'(s.v);
        o.field    = s.field;
        o.hstart   = (s.h == 0);
        o.vstart   = (s.h == 0) && (s.v == 0);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d blank=%b sync=%b field=%b hs=%b vs=%b",
                         o.h, o.v, o.blank, o.sync, o.field, o.hstart, o.vstart);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic dce, input logic drst, input logic dil,
                        input logic sce, input logic srst, input logic sil);
        d_ce = dce; d_rst = drst; d_il = dil;
        s_ce = sce; s_rst = srst; s_il = sil;
        @(posedge clk);
        md = drst ? mstate_t'('0) : (dce ? m_step(md, TD, dil) : md);
        ms = srst ? mstate_t'('0) : (sce ? m_step(ms, TS, sil) : ms);
        q_d.push_back(m_decode(md, TD));
        q_s.push_back(m_decode(ms, TS));
        #2;
    endtask

    task automatic dtick(input logic ce, input logic rst, input logic il);
        tick(ce, rst, il, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stick(input logic ce, input logic rst, input logic il);
        tick(1'b0, 1'b0, 1'b0, ce, rst, il);
    endtask

    // Monitor: every clock presents a position on both instances.
    obs_t got_d, got_s;
    assign got_d = {d_blank, d_sync, d_hcount, d_vcount, d_field, d_hstart, d_vstart};
    assign got_s = {s_blank, s_sync, s_hcount, s_vcount, s_field, s_hstart, s_vstart};

    always @(negedge clk) begin
        obs_t e;
        cyc++;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            n_chk++;
            if (got_d !== e) begin
                n_err++;
                $display("FAIL sb_default cycle=%0d got %s expected %s", cyc, fmt(got_d), fmt(e));
            end
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            n_chk++;
            if (got_s !== e) begin
                n_err++;
                $display("FAIL sb_small cycle=%0d got %s expected %s", cyc, fmt(got_s), fmt(e));
            end
        end
    end

    function automatic logic il_at(input int t);
        return (t >= 353 && t <= 1088) || (t > 1312);
    endfunction

    initial begin
        int last_hs, hs_run, nv, vs_lines;
        logic pb0, ps0, pb1;
        int exp_vs_t[10] = '{0, 176, 352, 528, 720, 896, 1088, 1264, 1440, 1632};
        int exp_vs_f[10] = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0};

        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_hstart", int'(d_hstart), 1);
        chk("reset_vstart", int'(d_vstart), 1);

        // Default timing, ce held high for two lines.
        last_hs = 0; hs_run = 0; pb0 = 1'b0; ps0 = 1'b0;
        for (int i = 1; i <= 2 * 896 + 4; i++) begin
            dtick(1'b1, 1'b0, 1'b0);
            if (d_hstart) begin
                chk("hstart_period", i - last_hs, 896);
                last_hs = i;
            end
            if (d_blank[0] && !pb0) chk("hblank_rise_h", int'(d_hcount), 720);
            if (!d_blank[0] && pb0) chk("hblank_fall_h", int'(d_hcount), 0);
            if (d_sync[0] && !ps0) chk("hsync_rise_h", int'(d_hcount), 744);
            if (d_sync[0]) hs_run++;
            if (!d_sync[0] && ps0) begin
                chk("hsync_fall_h", int'(d_hcount), 808);
                chk("hsync_width", hs_run, 64);
                hs_run = 0;
            end
            pb0 = d_blank[0];
            ps0 = d_sync[0];
        end
        chk("run_end_h", int'(d_hcount), 4);
        chk("run_end_v", int'(d_vcount), 2);

        // ce pulsed 1-in-3: 300 advances, holds in between.
        for (int i = 0; i < 900; i++) dtick((i % 3) == 0, 1'b0, 1'b0);
        chk("ce3_end_h", int'(d_hcount), 304);
        chk("ce3_end_v", int'(d_vcount), 2);

        // Reset with ce low, then reset inside horizontal sync.
        dtick(1'b0, 1'b1, 1'b0);
        chk("rst_noce_h", int'(d_hcount), 0);
        for (int i = 0; i < 780; i++) dtick(1'b1, 1'b0, 1'b0);
        chk("pre_rst_sync", int'(d_sync), 1);
        chk("pre_rst_blank", int'(d_blank), 1);
        dtick(1'b1, 1'b1, 1'b0);
        chk("rst_sync", int'(d_sync), 0);
        chk("rst_blank", int'(d_blank), 0);
        chk("rst_h", int'(d_hcount), 0);

        // Small timing: progressive, interlaced, and mid-frame interlace toggles.
        nv = 0; vs_lines = 0; pb1 = 1'b0;
        for (int t = 0; t <= 1640; t++) begin
            if (t > 0) stick(1'b1, 1'b0, il_at(t));
            if (s_vstart) begin
                if (nv < 10) begin
                    chk("vstart_tick", t, exp_vs_t[nv]);
                    chk("vstart_field", int'(s_field), exp_vs_f[nv]);
                end
                nv++;
            end
            if (t < 352 && s_sync[1]) vs_lines++;
            if (s_blank[1] && !pb1) chk("vblank_rise_v", int'(s_vcount), 6);
            if (s_vcount == 9'd11 && s_hcount == 10'd0) begin
                chk("ext_line_blank", int'(s_blank[1]), 1);
                chk("ext_line_sync", int'(s_sync[1]), 0);
            end
            pb1 = s_blank[1];
        end
        chk("vstart_count", nv, 10);
        chk("vsync_cycles", vs_lines, 64);

        // Reset while both syncs are active.
        stick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 123; i++) stick(1'b1, 1'b0, 1'b0);
        chk("s_pre_rst_sync", int'(s_sync), 3);
        chk("s_pre_rst_blank", int'(s_blank), 3);
        chk("s_pre_rst_v", int'(s_vcount), 7);
        stick(1'b1, 1'b1, 1'b0);
        chk("s_rst_sync", int'(s_sync), 0);
        chk("s_rst_blank", int'(s_blank), 0);
        chk("s_rst_v", int'(s_vcount), 0);
        chk("s_rst_vstart", int'(s_vstart), 1);
        stick(1'b1, 1'b0, 1'b0);
        chk("s_post_rst_h", int'(s_hcount), 1);

        @(negedge clk);
        #1;
        chk("queue_drain_d", q_d.size(), 0);
        chk("queue_drain_s", q_s.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
